soc_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between CPU inst-fetch and data ports.

---
 rtl/soc_bus_pkg.sv | 20 ++
 rtl/soc_arb_rr2.sv | 41 ++++
 rtl/soc_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and MMIO address map for the SoC memory-side bus.
// Response owners, the two-way grant encoding and the confreg register addresses.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA,
    OWN_MMIO
  } owner_e;

  typedef enum logic {
    G_INST,
    G_DATA
  } grant_e;

  localparam logic [31:0] MMIO_SWITCH_ADDR = 32'd1024;
  localparam logic [31:0] MMIO_LED_ADDR    = 32'd1028;

endpackage

// File: rtl/soc_arb_rr2.sv
// Two-way round-robin arbiter between inst-fetch and data RAM requests.
// Only a genuine conflict moves the last_grant pointer; a lone requester always wins.
module soc_arb_rr2
  import soc_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_inst,
  input  logic req_data,
  output logic gnt_inst,
  output logic gnt_data,
  output logic conflict
);

  grant_e last_grant;
  grant_e grant;

  assign conflict = req_inst & req_data;

  always_comb begin
    grant = G_INST;
    if (conflict) begin
      grant = (last_grant == G_DATA) ? G_INST : G_DATA;
    end else if (req_data) begin
      grant = G_DATA;
    end
  end

  assign gnt_inst = req_inst & (grant == G_INST);
  assign gnt_data = req_data & (grant == G_DATA);

  // DATA at reset so the first conflict goes to the fetch port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= G_DATA;
    end else if (conflict) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Shares one single-port RAM between CPU fetch and data ports and decodes the MMIO window.
// Optional perf counters: define SOC_ARB_PERF_CNT_EN.
module soc_mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int          AW         = 15,
  parameter logic [31:0] MMIO_BASE  = 32'h400,
  parameter logic [31:0] MMIO_BYTES = 32'h8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_ready,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          mmio_we,
  output logic [31:0]   mmio_addr,
  output logic [31:0]   mmio_wdata,
  input  logic [31:0]   mmio_rdata,
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_i_stall,
  output logic [31:0]   perf_d_stall
);

  logic   d_mmio;
  logic   d_ram_req;
  logic   mmio_acc;
  logic   gnt_inst;
  logic   gnt_data;
  logic   arb_conflict;
  logic   unused_addr_bits;

  logic        i_vld_p1;
  owner_e      d_own_p1;
  logic [31:0] mmio_rdata_p1;

  assign d_mmio    = (d_addr >= MMIO_BASE) && (d_addr < MMIO_BASE + MMIO_BYTES);
  assign d_ram_req = d_req & ~d_mmio;
  assign mmio_acc  = d_req & d_mmio;

  soc_arb_rr2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_inst (i_req),
    .req_data (d_ram_req),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data),
    .conflict (arb_conflict)
  );

  assign i_ready = gnt_inst;
  assign d_ready = gnt_data | mmio_acc;

  // Upper address bits alias onto the RAM; the fetch port never reaches MMIO
  assign mem_en    = gnt_inst | gnt_data;
  assign mem_we    = gnt_data & d_we;
  assign mem_addr  = gnt_data ? d_addr[AW+1:2] : i_addr[AW+1:2];
  assign mem_wdata = gnt_data ? d_wdata : '0;

  assign mmio_we    = mmio_acc & d_we;
  assign mmio_addr  = d_addr;
  assign mmio_wdata = d_wdata;

  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};

  // ---- p0 -> p1: response owner capture ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_vld_p1      <= 1'b0;
      d_own_p1      <= OWN_NONE;
      mmio_rdata_p1 <= '0;
    end else begin
      i_vld_p1 <= gnt_inst;
      if (gnt_data && !d_we) begin
        d_own_p1 <= OWN_DATA;
      end else if (mmio_acc && !d_we) begin
        d_own_p1 <= OWN_MMIO;
      end else begin
        d_own_p1 <= OWN_NONE;
      end
      if (mmio_acc && !d_we) begin
        mmio_rdata_p1 <= mmio_rdata;
      end
    end
  end

  assign i_rvalid = i_vld_p1;
  assign i_rdata  = i_vld_p1 ? mem_rdata : '0;
  assign d_rvalid = (d_own_p1 != OWN_NONE);

  always_comb begin
    d_rdata = '0;
    case (d_own_p1)
      OWN_DATA: d_rdata = mem_rdata;
      OWN_MMIO: d_rdata = mmio_rdata_p1;
      default:  d_rdata = '0;
    endcase
  end

`ifdef SOC_ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  logic [31:0] conflict_cnt;
  logic [31:0] i_stall_cnt;
  logic [31:0] d_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
      i_stall_cnt  <= '0;
      d_stall_cnt  <= '0;
    end else begin
      conflict_cnt <= sat_inc(conflict_cnt, arb_conflict);
      i_stall_cnt  <= sat_inc(i_stall_cnt, i_req & ~i_ready);
      d_stall_cnt  <= sat_inc(d_stall_cnt, d_req & ~d_ready);
    end
  end

  assign perf_conflict = conflict_cnt;
  assign perf_i_stall  = i_stall_cnt;
  assign perf_d_stall  = d_stall_cnt;
`else
  logic unused_conflict;
  assign unused_conflict = arb_conflict;
  assign perf_conflict   = '0;
  assign perf_i_stall    = '0;
  assign perf_d_stall    = '0;
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Scoreboard bench for soc_mem_arbiter: a behavioural RAM/confreg environment,
// a per-cycle arbitration model and queues of expected read responses.
module tb_soc_mem_arbiter;
  import soc_bus_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req, d_req, d_we;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic          i_ready, i_rvalid, d_ready, d_rvalid;
  logic [31:0]   i_rdata, d_rdata;
  logic          mem_en, mem_we, mmio_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, mmio_addr, mmio_wdata, mmio_rdata;
  logic [31:0]   perf_conflict, perf_i_stall, perf_d_stall;

  always #5 clk = ~clk;

  soc_mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .perf_conflict(perf_conflict), .perf_i_stall(perf_i_stall), .perf_d_stall(perf_d_stall)
  );

  // RAM and confreg environment
  logic [31:0] ram     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] rd_q = 32'h0;
  logic [31:0] sw_val = 32'h0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        rd_q <= ram[mem_addr[7:0]];
    end
  end
  assign mem_rdata = rd_q;

  always_comb begin
    mmio_rdata = 32'hBAD0_0000;
    if (mmio_addr == MMIO_SWITCH_ADDR)   mmio_rdata = sw_val;
    else if (mmio_addr == MMIO_LED_ADDR) mmio_rdata = 32'h0000_1ED0;
  end

  function automatic logic [31:0] mmio_exp(input logic [31:0] a);
    if (a == MMIO_SWITCH_ADDR) return sw_val;
    if (a == MMIO_LED_ADDR)    return 32'h0000_1ED0;
    return 32'hBAD0_0000;
  endfunction

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  grant_e      lg = G_DATA;
  logic        last_gi = 1'b0, last_gd = 1'b0;
  int          conf_n = 0, istall_n = 0, dstall_n = 0, iw = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One bus cycle: inputs already driven at posedge+1; grant checks at negedge, responses at posedge+1
  task automatic step();
    logic dm, dram, gi, gd;
    logic [31:0] e;
    @(negedge clk);
    dm   = d_req && (d_addr >= 32'h400) && (d_addr < 32'h408);
    dram = d_req && !dm;
    if (i_req && dram) begin
      gi = (lg == G_DATA);
      gd = !gi;
      lg = gi ? G_INST : G_DATA;
      conf_n++;
    end else begin
      gi = i_req;
      gd = dram;
    end
    if (i_req && !gi) istall_n++;
    if (d_req && !(gd || dm)) dstall_n++;
    if (i_req && !i_ready) iw++; else iw = 0;
    check("i_wait_max", 32'(iw <= 1), 32'd1);
    check("i_ready", i_ready, gi);
    check("d_ready", d_ready, gd | dm);
    check("mem_en", mem_en, gi | gd);
    if (gi || gd) begin
      check("mem_addr", mem_addr, gd ? d_addr[16:2] : i_addr[16:2]);
      check("mem_we", mem_we, gd & d_we);
      check("mem_wdata", mem_wdata, gd ? d_wdata : 32'h0);
    end
    check("mmio_we", mmio_we, dm & d_we);
    if (dm) check("mmio_addr", mmio_addr, d_addr);
    if (dm && d_we) check("mmio_wdata", mmio_wdata, d_wdata);
    if (gi) iq.push_back(exp_mem[i_addr[9:2]]);
    if (gd && !d_we) dq.push_back(exp_mem[d_addr[9:2]]);
    if (gd && d_we) exp_mem[d_addr[9:2]] = d_wdata;
    if (dm && !d_we) dq.push_back(mmio_exp(d_addr));
    last_gi = gi;
    last_gd = gd | dm;
    @(posedge clk);
    #1;
    check("i_rvalid", i_rvalid, 32'(iq.size() != 0));
    if (iq.size() != 0) begin
      e = iq.pop_front();
      if (i_rvalid) check("i_rdata", i_rdata, e);
    end
    check("d_rvalid", d_rvalid, 32'(dq.size() != 0));
    if (dq.size() != 0) begin
      e = dq.pop_front();
      if (d_rvalid) check("d_rdata", d_rdata, e);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_rvalid", i_rvalid, 32'h0);
    check("rst_d_rvalid", d_rvalid, 32'h0);
    check("rst_perf_conflict", perf_conflict, 32'h0);
    reset = 1'b0;
    iq.delete(); dq.delete();
    lg = G_DATA; conf_n = 0; istall_n = 0; dstall_n = 0; iw = 0;
    last_gi = 1'b0; last_gd = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 32'hA500_0000 | (k << 8) | (k ^ 32'h3C);
      exp_mem[k] = 32'hA500_0000 | (k << 8) | (k ^ 32'h3C);
    end
    idle_inputs();
    @(posedge clk); #1;
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_i_ready", i_ready, 32'h0);
    check("rst_mem_en", mem_en, 32'h0);
    check("rst_perf_i_stall", perf_i_stall, 32'h0);
    check("rst_perf_d_stall", perf_d_stall, 32'h0);
    do_reset();

    // Fetch only at 0x10
    i_req = 1'b1; i_addr = 32'h10;
    step();
    idle_inputs();
    step();

    // Simultaneous fetch and data read after reset: fetch first
    do_reset();
    i_req = 1'b1; i_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step();
    i_req = 1'b0;
    step();
    idle_inputs();
    step();
`ifdef SOC_ARB_PERF_CNT_EN
    check("t2_perf_conflict", perf_conflict, 32'd1);
    check("t2_perf_d_stall", perf_d_stall, 32'd1);
`else
    check("t2_perf_conflict", perf_conflict, 32'd0);
    check("t2_perf_d_stall", perf_d_stall, 32'd0);
`endif

    // Both held, new address per grant: strict alternation
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      step();
      if (last_gi) i_addr = i_addr + 32'd4;
      if (last_gd) d_addr = d_addr + 32'd4;
    end
    idle_inputs();
    step();

    // MMIO write to LED alongside a fetch
    i_req = 1'b1; i_addr = 32'h50;
    d_req = 1'b1; d_we = 1'b1; d_addr = MMIO_LED_ADDR; d_wdata = 32'h1234;
    step();
    idle_inputs();
    step();

    // MMIO switch read
    sw_val = 32'h5A;
    d_req = 1'b1; d_we = 1'b0; d_addr = MMIO_SWITCH_ADDR;
    step();
    idle_inputs();
    step();

    // RAM write, read back, and an aliased address
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hCAFE_F00D;
    step();
    d_we = 1'b0;
    step();
    d_addr = 32'h0002_0020;
    step();
    idle_inputs();
    step();

    // Reset arriving while a granted read is still in flight
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    @(negedge clk);
    check("mid_rst_d_ready", d_ready, 32'h1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_d_rvalid", d_rvalid, 32'h0);
    idle_inputs();
    reset = 1'b0;
    iq.delete(); dq.delete();
    lg = G_DATA; conf_n = 0; istall_n = 0; dstall_n = 0; iw = 0;
    step();
    step();

    // Random traffic, requests held until granted
    for (int k = 0; k < 300; k++) begin
      if (!(i_req && !last_gi)) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!(d_req && !last_gd)) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        case ($urandom_range(0, 7))
          0:       d_addr = MMIO_SWITCH_ADDR;
          1:       d_addr = MMIO_LED_ADDR;
          2:       d_addr = 32'd1032;
          3:       d_addr = 32'd1020;
          default: d_addr = 32'($urandom_range(0, 255)) << 2;
        endcase
      end
      sw_val = $urandom;
      step();
    end
    idle_inputs();
    step();
`ifdef SOC_ARB_PERF_CNT_EN
    check("perf_conflict", perf_conflict, 32'(conf_n));
    check("perf_i_stall", perf_i_stall, 32'(istall_n));
    check("perf_d_stall", perf_d_stall, 32'(dstall_n));
`else
    check("perf_conflict", perf_conflict, 32'd0);
    check("perf_i_stall", perf_i_stall, 32'd0);
    check("perf_d_stall", perf_d_stall, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
